// File: rtl/microondas_pkg.sv
// -----------------------------------------------------------------------------
// microondas_pkg
// Shared types and helpers for the microwave cook-cycle controller.
//   - state_t     : controller state encoding (IDLE/COOK/PAUSE/DONE)
//   - bcd_t       : one BCD digit
//   - cook_time_t : MM:SS as four BCD digits
//   - MAX_TIME / QUICK_TIME / ZERO_TIME constants
//   - BCD add-30, decrement and zero-test helpers, per-state output decode
// -----------------------------------------------------------------------------
package microondas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } cook_time_t;

    localparam cook_time_t MAX_TIME   = '{4'd9, 4'd9, 4'd5, 4'd9};
    localparam cook_time_t QUICK_TIME = '{4'd0, 4'd0, 4'd3, 4'd0};
    localparam cook_time_t ZERO_TIME  = '{4'd0, 4'd0, 4'd0, 4'd0};

    function automatic logic is_zero(input cook_time_t t);
        return (t == ZERO_TIME);
    endfunction

    // Add 30 s. The only way to exceed 99:59 is a minute carry out of 99,
    // so saturation is handled right at that carry.
    function automatic cook_time_t bcd_add30(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.sec_tens >= 4'd3) begin
            r.sec_tens = t.sec_tens - 4'd3;
            if (t.min_ones == 4'd9) begin
                r.min_ones = 4'd0;
                if (t.min_tens == 4'd9)
                    r = MAX_TIME;
                else
                    r.min_tens = t.min_tens + 4'd1;
            end else begin
                r.min_ones = t.min_ones + 4'd1;
            end
        end else begin
            r.sec_tens = t.sec_tens + 4'd3;
        end
        return r;
    endfunction

    // Decrement by one second with BCD borrows; 00:00 stays put.
    function automatic cook_time_t bcd_dec(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (!is_zero(t)) begin
            if (t.sec_ones != 4'd0) begin
                r.sec_ones = t.sec_ones - 4'd1;
            end else begin
                r.sec_ones = 4'd9;
                if (t.sec_tens != 4'd0) begin
                    r.sec_tens = t.sec_tens - 4'd1;
                end else begin
                    r.sec_tens = 4'd5;
                    if (t.min_ones != 4'd0) begin
                        r.min_ones = t.min_ones - 4'd1;
                    end else begin
                        r.min_ones = 4'd9;
                        r.min_tens = t.min_tens - 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    // {magnetron_on, lamp_on, beep} for a given state and door level.
    function automatic logic [2:0] state_outputs(input state_t s, input logic door);
        logic [2:0] o;
        case (s)
            ST_COOK:  o = 3'b110;
            ST_DONE:  o = {1'b0, door, 1'b1};
            default:  o = {1'b0, door, 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/microondas_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Clock-enable divider: emits a one-cycle tick every TICK_DIV cycles.
// No derived clock is produced.
//   clock_in : system clock
//   reset    : synchronous active-high reset
//   clear    : hold the counter at 0 (and suppress tick) while high
//   tick     : one-cycle enable when the counter sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock_in,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST) && !clear;

    always_ff @(posedge clock_in) begin
        if (reset || clear)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/microondas_ctrl.sv
// -----------------------------------------------------------------------------
// microondas_ctrl
// Microwave cook-cycle controller: BCD cook time (MM:SS), IDLE/COOK/PAUSE/DONE
// sequencing from front-panel keys and the door switch, second countdown from
// an internal tick, magnetron/lamp/beeper drive.
//   clock_in, reset                  : clock, synchronous active-high reset
//   btn_start, btn_stop, btn_add30   : single-cycle key pulses
//   door_open                        : door level, 1 = open
//   min_tens..sec_ones               : BCD cook time to the display
//   magnetron_on, lamp_on, beep      : registered actuator drives
//   state                            : 0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
// -----------------------------------------------------------------------------
module microondas_ctrl
    import microondas_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_add30,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       lamp_on,
    output logic       beep,
    output logic [1:0] state
);
    localparam int BW = $clog2(BEEP_TICKS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_t     cur_state;
    cook_time_t tm;
    cook_time_t tm_dec;
    logic [BW-1:0] beep_cnt;
    logic       tick;
    logic       tick_clear;

    // The divider only runs in COOK and DONE. Holding it cleared elsewhere
    // means every entry into COOK starts a fresh second; COOK->DONE happens
    // on a tick, where the divider wraps to 0 by itself.
    assign tick_clear = (cur_state != ST_COOK) && (cur_state != ST_DONE);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock_in (clock_in),
        .reset    (reset),
        .clear    (tick_clear),
        .tick     (tick)
    );

    assign tm_dec = bcd_dec(tm);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cur_state    <= ST_IDLE;
            tm           <= ZERO_TIME;
            beep_cnt     <= '0;
            magnetron_on <= 1'b0;
            lamp_on      <= 1'b0;
            beep         <= 1'b0;
        end else begin
            // Default: outputs for staying in the current state; any
            // transition below overrides with the target state's outputs.
            {magnetron_on, lamp_on, beep} <= state_outputs(cur_state, door_open);
            case (cur_state)
                ST_IDLE: begin
                    if (btn_stop) begin
                        tm <= ZERO_TIME;
                    end else if (btn_start && !door_open) begin
                        if (is_zero(tm))
                            tm <= QUICK_TIME;
                        cur_state <= ST_COOK;
                        {magnetron_on, lamp_on, beep} <= state_outputs(ST_COOK, door_open);
                    end else if (btn_add30) begin
                        tm <= bcd_add30(tm);
                    end
                end
                ST_COOK: begin
                    if (door_open || btn_stop) begin
                        cur_state <= ST_PAUSE;
                        {magnetron_on, lamp_on, beep} <= state_outputs(ST_PAUSE, door_open);
                    end else if (btn_add30) begin
                        // add30 wins over a coincident tick; that decrement is lost
                        tm <= bcd_add30(tm);
                    end else if (tick) begin
                        tm <= tm_dec;
                        if (is_zero(tm_dec)) begin
                            cur_state <= ST_DONE;
                            beep_cnt  <= '0;
                            {magnetron_on, lamp_on, beep} <= state_outputs(ST_DONE, door_open);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_stop) begin
                        tm        <= ZERO_TIME;
                        cur_state <= ST_IDLE;
                        {magnetron_on, lamp_on, beep} <= state_outputs(ST_IDLE, door_open);
                    end else if (btn_start && !door_open) begin
                        cur_state <= ST_COOK;
                        {magnetron_on, lamp_on, beep} <= state_outputs(ST_COOK, door_open);
                    end else if (btn_add30) begin
                        tm <= bcd_add30(tm);
                    end
                end
                ST_DONE: begin
                    if (btn_stop) begin
                        beep_cnt  <= '0;
                        cur_state <= ST_IDLE;
                        {magnetron_on, lamp_on, beep} <= state_outputs(ST_IDLE, door_open);
                    end else if (tick) begin
                        if (beep_cnt == BEEP_LAST) begin
                            beep_cnt  <= '0;
                            cur_state <= ST_IDLE;
                            {magnetron_on, lamp_on, beep} <= state_outputs(ST_IDLE, door_open);
                        end else begin
                            beep_cnt <= beep_cnt + 1'b1;
                        end
                    end
                end
                default: cur_state <= ST_IDLE;
            endcase
        end
    end

    assign state    = cur_state;
    assign min_tens = tm.min_tens;
    assign min_ones = tm.min_ones;
    assign sec_tens = tm.sec_tens;
    assign sec_ones = tm.sec_ones;

endmodule
